// File: rtl/wb_skid_buffer.sv
// Purpose : two-entry valid/ready skid buffer registering the select-mux result ahead of writeback.
// Latency : one cycle from accept to out_valid/out_data.
// Backpres: absorbs two beats with out_ready low; in_ready comes from registered state only.
//
// Ports:
//   clk, rst_n          - rising-edge clock, synchronous active-low reset
//   flush               - synchronous discard of all held beats (branch redirect)
//   in_valid/in_ready   - upstream handshake, in_data carries the beat
//   out_valid/out_ready - downstream handshake, out_data carries the head beat
//   occupancy           - number of held beats (0, 1 or 2)
//
// Build option: WB_SKID_ISOLATE_EN forces out_data to zero while out_valid is low,
// so the writeback logic does not toggle on stale data.
module wb_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             drain;

    // Both handshakes are built from registered outputs, so out_ready never
    // reaches in_ready and in_valid never reaches out_valid combinationally.
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // in_ready, out_valid and occupancy are flops updated alongside state so
    // they always match it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else if (flush) begin
            // A drain this cycle still completes downstream; an accept is dropped.
            // Data registers keep their contents, only the state empties.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        // Pass-through at full rate: head replaced in place.
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q    <= in_data;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                        occupancy <= 2'd2;
                    end else if (drain) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        main_q    <= skid_q;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

`ifdef WB_SKID_ISOLATE_EN
    assign out_data = out_valid ? main_q : '0;
`else
    assign out_data = main_q;
`endif

endmodule

// File: tb/tb_wb_skid_buffer.sv
// Purpose : self-checking bench for wb_skid_buffer against a queue-based reference.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpres: the reference applies its own in_ready rule (fewer than two beats held).
module tb_wb_skid_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    // Reference: FIFO of held beats plus the last value that sat at the head,
    // which is what a non-isolated output shows while idle.
    logic [15:0] mq[$];
    logic [15:0] mhead = 16'h0000;

    always #5 clk = ~clk;

    wb_skid_buffer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    function automatic logic [15:0] exp_data();
`ifdef WB_SKID_ISOLATE_EN
        return (mq.size() > 0) ? mq[0] : 16'h0000;
`else
        return mhead;
`endif
    endfunction

    function automatic logic [15:0] idle_data(input logic [15:0] last);
`ifdef WB_SKID_ISOLATE_EN
        return (last == last) ? 16'h0000 : 16'h0000;
`else
        return last;
`endif
    endfunction

    // One clock: drive inputs, advance the reference at the edge, settle.
    task automatic step(input logic v, input logic [15:0] d, input logic ordy,
                        input logic fl, input logic rs);
        int  n;
        bit  acc;
        bit  drn;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rs;
        @(posedge clk);
        if (!rs) begin
            mq.delete();
            mhead = 16'h0000;
        end else begin
            n   = mq.size();
            acc = v && (n < 2);
            drn = (n > 0) && ordy;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (fl) mq.delete();
            else if (mq.size() > 0) mhead = mq[0];
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b occ=%0d out_data=%h required 0 1 0 0000",
                     out_valid, in_ready, occupancy, out_data);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: in_ready=%b required 1", i, in_ready);
            end
            step(1'b1, 16'(i), 1'b1, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(i) || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream_out[%0d]: out_valid=%b out_data=%h occ=%0d required 1 %h 1",
                         i, out_valid, out_data, occupancy, 16'(i));
            end
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: out_valid=%b occ=%0d required 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 16'hA000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hA001, 1'b0, 1'b0, 1'b1);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hA000) begin
            errors++;
            $display("FAIL bp_full: occ=%0d in_ready=%b out_data=%h required 2 0 a000",
                     occupancy, in_ready, out_data);
        end
        step(1'b1, 16'hA002, 1'b0, 1'b0, 1'b1);
        checks++;
        if (occupancy !== 2'd2 || out_data !== 16'hA000) begin
            errors++;
            $display("FAIL bp_hold: occ=%0d out_data=%h required 2 a000", occupancy, out_data);
        end
        // Drain A000; A002 still refused because in_ready was low this cycle.
        step(1'b1, 16'hA002, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'hA001 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_data=%h occ=%0d in_ready=%b required a001 1 1",
                     out_data, occupancy, in_ready);
        end
        step(1'b1, 16'hA002, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'hA002 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: out_data=%h occ=%0d out_valid=%b required a002 1 1",
                     out_data, occupancy, out_valid);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_empty: occ=%0d required 0", occupancy);
        end
    endtask

    task automatic test_accept_drain();
        step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h2222, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_data !== 16'h2222 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL accept_drain: out_data=%h occ=%0d out_valid=%b required 2222 1 1",
                     out_data, occupancy, out_valid);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two: out_valid=%b occ=%0d in_ready=%b required 0 0 1",
                     out_valid, occupancy, in_ready);
        end
        // Flush while accepting from empty: the beat is discarded.
        step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data === 16'h1234) begin
                errors++;
                $display("FAIL flush_discard[%0d]: out_valid=%b occ=%0d out_data=%h required 0 0 not-1234",
                         i, out_valid, occupancy, out_data);
            end
            step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h8888, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b occ=%0d out_data=%h required 0 1 0 0000",
                     out_valid, in_ready, occupancy, out_data);
        end
    endtask

    task automatic test_idle_data();
        step(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== idle_data(16'h5A5A)) begin
            errors++;
            $display("FAIL idle_data: out_valid=%b out_data=%h required 0 %h",
                     out_valid, out_data, idle_data(16'h5A5A));
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) != 0));
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                occupancy !== 2'(mq.size()) || out_data !== exp_data()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: vld=%b rdy=%b occ=%0d dat=%h required %b %b %0d %h",
                             c, out_valid, in_ready, occupancy, out_data,
                             (mq.size() > 0), (mq.size() < 2), mq.size(), exp_data());
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_accept_drain();
        test_flush();
        test_reset_mid();
        test_idle_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_skid_buffer.md
# wb_skid_buffer

Two-entry valid/ready skid buffer that registers the 16-bit result from the datapath's operand/result select mux before it reaches the writeback port of the register file. It gives full-throughput pipelining with no combinational path from `out_ready` to `in_ready`. It also supports a synchronous pipeline flush for branch redirects.

## Interface

Parameters:
- `WIDTH`, 16: data width; must match the upstream mux output width.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: synchronous reset, active-low.
- `flush`, input, 1: synchronous discard of all buffered entries.
- `in_valid`, input, 1: upstream data valid.
- `in_ready`, output, 1: buffer can accept a beat this cycle.
- `in_data`, input, WIDTH: data from the select mux output.
- `out_valid`, output, 1: `out_data` holds a valid beat.
- `out_ready`, input, 1: downstream accepts `out_data` this cycle.
- `out_data`, output, WIDTH: buffered data toward writeback.
- `occupancy`, output, 2: number of held entries (0, 1 or 2).

## Operation

- Accept happens when `in_valid && in_ready`. Drain happens when `out_valid && out_ready`.
- The buffer holds two registers: `main_q`, which drives `out_data`, and `skid_q`.
- State machine:
  - EMPTY: occupancy 0.
  - ONE: `main_q` valid.
  - TWO: `main_q` and `skid_q` both valid.
- Transitions (without flush):
  - EMPTY, accept: `main_q <= in_data`, go to ONE.
  - ONE, accept and drain: `main_q <= in_data`, stay in ONE.
  - ONE, accept, no drain: `skid_q <= in_data`, go to TWO.
  - ONE, drain, no accept: go to EMPTY.
  - TWO, drain: `main_q <= skid_q`, go to ONE.
  - Any other case: hold.
- `in_ready = (state != TWO)`. It is a pure function of registered state.
- `out_valid = (state != EMPTY)`.
- `occupancy`: EMPTY=0, ONE=1, TWO=2.
- Ordering: output order always equals input order. No beat is ever dropped or duplicated except by `flush`.
- Flush:
  - When `flush=1`, the next state is EMPTY, regardless of accept or drain in the same cycle.
  - A beat accepted in the flush cycle is discarded.
  - A drain in the flush cycle is still a valid transfer downstream; flush does not retract the current `out_data`.
- Reset:
  - When `rst_n=0` at a clock edge, state goes to EMPTY and `main_q`/`skid_q` go to 0.
  - Reset has priority over `flush` and all handshakes.
  - After reset: `out_valid=0`, `out_data=0`, `in_ready=1`, `occupancy=0`.
- Data registers load only on the transitions listed above. They hold their value otherwise.

## Timing

- Latency: a beat accepted at edge N is visible on `out_data` with `out_valid=1` after edge N, i.e. one cycle.
- Throughput: one beat per cycle sustained when `out_ready=1`.
- Backpressure:
  - With `out_ready` low, the buffer absorbs 2 beats.
  - `in_ready` drops in the cycle after the second accept.
- Release: `in_ready` returns high one cycle after the first drain from TWO.
- Combinational paths: there is no path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Mid-operation reset: an in-flight handshake in the reset cycle is void on both sides.

## Configuration

- `WB_SKID_ISOLATE_EN`:
  - Defined: `out_data` is forced to all-zeros whenever `out_valid=0`. This is operand isolation that suppresses toggling into writeback logic for power.
  - Undefined: `out_data = main_q` at all times. Stale data is visible while `out_valid=0`.
- Handshake behaviour and occupancy are identical in both builds.

## Test plan

- Reset, then stream: hold `rst_n=0` for 2 cycles, then send 0x0001..0x0008 back-to-back with `out_ready=1`.
  - `in_ready`=1 throughout.
  - Outputs are 0x0001..0x0008 on consecutive cycles, each one cycle after its input.
- Backpressure fill: `out_ready=0`, send 0xA000, 0xA001, 0xA002.
  - The first two are accepted and `occupancy`=2.
  - `in_ready`=0, so 0xA002 is held upstream.
  - Raising `out_ready` yields 0xA000, 0xA001, 0xA002 in order.
- Simultaneous accept and drain in ONE: with 0x1111 held, present 0x2222 with `out_ready=1`.
  - Next cycle `out_data`=0x2222 and `occupancy`=1.
- Flush: from TWO (0xBEEF, 0xCAFE), assert `flush` with `in_valid=1` and `in_data=0x1234`.
  - Next cycle: `out_valid`=0, `occupancy`=0.
  - 0x1234 never appears on the output.
- Reset mid-stream: from TWO, pull `rst_n` low for one cycle.
  - Next cycle: `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - `out_data`=0x0000 in both builds.
- Isolation build check: with `WB_SKID_ISOLATE_EN` defined, drain the last beat 0x5A5A.
  - The following idle cycle shows `out_data`=0x0000.
  - Without the macro, the idle cycle shows 0x5A5A.
